dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Data-memory responder for the pipelined datapath's M stage: serves load/store requests and returns
//  dhit/ReadData. Direct-mapped, write-back, write-allocate cache with 128-bit lines.
//  Misses go to main memory over a req/ack line interface. The pipeline stalls while dhit=0.
// PARAMETERS
//  NLINES   4   number of cache lines; power of 2, >=2; IDX_W = log2(NLINES)
//  ADDR_W   32  byte address width; tag = addr[ADDR_W-1:4+IDX_W], index = addr[4+IDX_W-1:4]
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    synchronous, active-high
//  rd_en      in   1    load in M stage
//  wr_en      in   1    store in M stage
//  byte_en    in   1    store is a byte store (data in wdata[7:0])
//  addr       in   32   byte address (ALUOutM)
//  wdata      in   32   store data (WriteDataM)
//  rdata      out  32   load data (ReadData); combinational
//  dhit       out  1    1 = request served this cycle or no request; 0 = stall
//  mem_req    out  1    line transfer request to memory
//  mem_we     out  1    1 = write-back, 0 = refill
//  mem_addr   out  32   line-aligned address ([3:0] = 0)
//  mem_wdata  out  128  victim line; word0 in [31:0]
//  mem_rdata  in   128  refill line; word0 in [31:0]
//  mem_ack    in   1    transfer complete; sampled only while mem_req=1
// BEHAVIOUR
//  - Word select: addr[3:2]. Byte lane for byte stores is big-endian:
//    addr[1:0]=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]. Other bytes are untouched.
//  - Word loads return the whole word. Byte extraction stays in W; addr[1:0] is ignored on loads.
//  - Per-line state: valid, dirty, tag, 128-bit data.
//  - Reset:
//    - all valid and dirty bits are cleared; state = IDLE.
//    - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//    - dhit=1, rdata=0. Data array contents are don't-care.
//  - FSM states: IDLE, WRITEBACK, REFILL. Outputs are Moore except dhit and rdata.
//  - IDLE, no request: dhit=1, rdata=0.
//  - IDLE, hit (valid and tag match):
//    - dhit=1 in the same cycle (zero-latency hit).
//    - Load: rdata = selected word, combinational.
//    - Store: word or byte is written at this clock edge and dirty is set.
//  - IDLE, miss:
//    - dhit=0 and rdata=0 combinationally.
//    - Next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL.
//  - WRITEBACK:
//    - mem_req=1, mem_we=1; mem_addr = {victim tag, index, 4'b0}; mem_wdata = victim line.
//    - dhit=0. On mem_ack: next state REFILL and dirty is cleared.
//  - REFILL:
//    - mem_req=1, mem_we=0; mem_addr = {addr[31:4], 4'b0}. dhit=0.
//    - On mem_ack: the line is written from mem_rdata with valid=1, dirty=0 and the new tag; next state IDLE.
//    - The held request then hits on the following cycle; a store merges then.
//  - Miss latency, clean victim: 1 (miss detect) + refill-ack cycles, then the hit cycle.
//  - Minimum miss latency: 2 stall cycles when a clean victim is acked immediately;
//    3 stall cycles for a dirty victim.
//  - The requester holds rd_en, wr_en, addr and wdata stable while dhit=0.
//    This is guaranteed by the pipeline stall; the controller does not register the request.
//  - rd_en and wr_en together: treated as a store.
//  - mem_ack outside WRITEBACK/REFILL is ignored.
//  - mem_ack is never required in the same cycle mem_req rises; if present in that cycle, it is honoured.
//  - Reset mid-miss: at the next edge, state=IDLE and mem_req=0.
//    - An aborted refill does not set valid.
//    - The memory model must drop a request whose mem_req deasserts.
//  - Index collision: a new tag evicts the line; there is no associativity and no replacement choice.
// TESTING
//  1. Reset, then load 0x100 -> dhit=0, REFILL with mem_addr=0x100. Ack after 3 cycles with line
//     {0x44,0x33,0x22,0x11} -> next cycle dhit=1, rdata=0x11.
//  2. Load 0x104 right after test 1 -> dhit=1 in the same cycle, rdata=0x22, mem_req stays 0.
//  3. Byte store 0xAB to 0x101 on the cached line -> word at 0x100 reads 0x00AB0011.
//     The line becomes dirty; no memory traffic.
//  4. With NLINES=4, load 0x140 (same index, new tag) -> WRITEBACK first: mem_we=1, mem_addr=0x100,
//     mem_wdata[31:0]=0x00AB0011. Then REFILL with mem_addr=0x140; dhit=1 after ack.
//  5. Store 0xDEADBEEF to 0x200 (miss, clean) -> REFILL, then the store merges.
//     A load of 0x200 returns 0xDEADBEEF with no further mem_req.
//  6. Assert reset during REFILL before ack -> mem_req=0 next cycle.
//     A load of the same address misses again.

Source files
------------

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dcache_ctrl
// Brief   : Direct-mapped, write-back, write-allocate data cache controller
//           with 128-bit lines and a req/ack line interface to main memory.
// Revision: 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int NLINES = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic              byte_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              dhit,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ack
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2
    } state_t;

    state_t             r_state;
    logic [NLINES-1:0]  r_valid;
    logic [NLINES-1:0]  r_dirty;
    logic [TAG_W-1:0]   r_tag  [NLINES];
    logic [127:0]       r_data [NLINES];

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_word;
    logic               w_req;
    logic               w_hit;
    logic               w_serve;
    logic [31:0]        w_word_data;

    assign w_idx       = addr[4+IDX_W-1:4];
    assign w_tag       = addr[ADDR_W-1:4+IDX_W];
    assign w_word      = addr[3:2];
    assign w_req       = rd_en | wr_en;
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_serve     = (r_state == S_IDLE) && w_hit;
    assign w_word_data = r_data[w_idx][{w_word, 5'b00000} +: 32];

    assign dhit  = !w_req || w_serve;
    // A simultaneous rd_en/wr_en is a store, so only pure loads drive rdata.
    assign rdata = (w_serve && rd_en && !wr_en) ? w_word_data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_valid   <= '0;
            r_dirty   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_req && w_hit) begin
                        if (wr_en) begin
                            r_dirty[w_idx] <= 1'b1;
                        end
                    end else if (w_req) begin
                        mem_req <= 1'b1;
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state   <= S_WRITEBACK;
                            mem_we    <= 1'b1;
                            mem_addr  <= {r_tag[w_idx], w_idx, 4'b0000};
                            mem_wdata <= r_data[w_idx];
                        end else begin
                            r_state  <= S_REFILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {addr[ADDR_W-1:4], 4'b0000};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        r_state        <= S_REFILL;
                        r_dirty[w_idx] <= 1'b0;
                        mem_we         <= 1'b0;
                        mem_addr       <= {addr[ADDR_W-1:4], 4'b0000};
                        mem_wdata      <= '0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        r_state        <= S_IDLE;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_tag[w_idx]   <= w_tag;
                        mem_req        <= 1'b0;
                        mem_addr       <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Line data needs no reset; validity alone governs whether it is used.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_REFILL && mem_ack) begin
                r_data[w_idx] <= mem_rdata;
            end else if (w_serve && wr_en) begin
                if (byte_en) begin
                    r_data[w_idx][{w_word, ~addr[1:0], 3'b000} +: 8] <= wdata[7:0];
                end else begin
                    r_data[w_idx][{w_word, 5'b00000} +: 32] <= wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dcache_ctrl
// Brief   : Directed self-checking bench for dcache_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         rd_en, wr_en, byte_en;
    logic [31:0]  addr, wdata, rdata;
    logic         dhit, mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int checks   = 0;
    int failures = 0;

    dcache_ctrl #(.NLINES(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .byte_en   (byte_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b1; rd_en = 0; wr_en = 0; byte_en = 0; addr = 0; wdata = 0;
        mem_ack = 0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (dhit !== 1'b1) begin failures++; $display("FAIL reset_dhit got=%0b exp=1", dhit); end
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_req_we got=%b%b exp=00", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 128'd0) begin failures++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0", mem_addr, mem_wdata); end
    endtask

    task automatic test_load_miss();
        @(negedge clk); rd_en = 1; addr = 32'h100; #1;
        checks++; if (dhit !== 1'b0 || rdata !== 32'd0) begin failures++; $display("FAIL miss_detect dhit=%b rdata=%h exp 0/0", dhit, rdata); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin failures++; $display("FAIL refill_req req=%b we=%b addr=%h exp 1/0/100", mem_req, mem_we, mem_addr); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (mem_req !== 1'b1 || dhit !== 1'b0) begin failures++; $display("FAIL refill_hold req=%b dhit=%b exp 1/0", mem_req, dhit); end
        mem_ack = 1; mem_rdata = 128'h00000044_00000033_00000022_00000011;
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (dhit !== 1'b1 || rdata !== 32'h11) begin failures++; $display("FAIL refill_hit dhit=%b rdata=%h exp 1/00000011", dhit, rdata); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL refill_done_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_load_hit();
        @(negedge clk); addr = 32'h104; #1;
        checks++; if (dhit !== 1'b1 || rdata !== 32'h22) begin failures++; $display("FAIL hit_word1 dhit=%b rdata=%h exp 1/00000022", dhit, rdata); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hit_no_req got=%b exp=0", mem_req); end
    endtask

    task automatic test_byte_store();
        @(negedge clk); rd_en = 0; wr_en = 1; byte_en = 1; addr = 32'h101; wdata = 32'h000000AB; #1;
        checks++; if (dhit !== 1'b1) begin failures++; $display("FAIL bstore_dhit got=%b exp=1", dhit); end
        @(negedge clk); wr_en = 0; byte_en = 0; rd_en = 1; addr = 32'h100; #1;
        checks++; if (rdata !== 32'h00AB0011 || mem_req !== 1'b0) begin failures++; $display("FAIL bstore_read rdata=%h req=%b exp 00ab0011/0", rdata, mem_req); end
    endtask

    task automatic test_dirty_evict();
        @(negedge clk); addr = 32'h140; #1;
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL evict_miss dhit=%b exp=0", dhit); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin failures++; $display("FAIL wb_req req=%b we=%b addr=%h exp 1/1/100", mem_req, mem_we, mem_addr); end
        checks++; if (mem_wdata[31:0] !== 32'h00AB0011 || mem_wdata[63:32] !== 32'h22) begin failures++; $display("FAIL wb_data got=%h exp low words 00000022_00ab0011", mem_wdata); end
        mem_ack = 1;
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h140 || dhit !== 1'b0) begin failures++; $display("FAIL wb_to_refill req=%b we=%b addr=%h dhit=%b exp 1/0/140/0", mem_req, mem_we, mem_addr, dhit); end
        mem_ack = 1; mem_rdata = 128'h00000088_00000077_00000066_00000055;
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (dhit !== 1'b1 || rdata !== 32'h55) begin failures++; $display("FAIL evict_hit dhit=%b rdata=%h exp 1/00000055", dhit, rdata); end
    endtask

    task automatic test_store_miss();
        @(negedge clk); rd_en = 0; wr_en = 1; addr = 32'h200; wdata = 32'hDEADBEEF; #1;
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL smiss_dhit got=%b exp=0", dhit); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h200) begin failures++; $display("FAIL smiss_refill req=%b we=%b addr=%h exp 1/0/200", mem_req, mem_we, mem_addr); end
        mem_ack = 1; mem_rdata = 128'h000000A3_000000A2_000000A1_000000A0;
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (dhit !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL smiss_merge dhit=%b req=%b exp 1/0", dhit, mem_req); end
        @(negedge clk); wr_en = 0; rd_en = 1; #1;
        checks++; if (rdata !== 32'hDEADBEEF || dhit !== 1'b1) begin failures++; $display("FAIL smiss_read rdata=%h dhit=%b exp deadbeef/1", rdata, dhit); end
        @(negedge clk); addr = 32'h204; mem_ack = 1; #1;
        checks++; if (rdata !== 32'hA1) begin failures++; $display("FAIL smiss_neighbour rdata=%h exp=000000a1", rdata); end
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (mem_req !== 1'b0 || dhit !== 1'b1) begin failures++; $display("FAIL idle_ack_ignored req=%b dhit=%b exp 0/1", mem_req, dhit); end
    endtask

    task automatic test_reset_mid_refill();
        @(negedge clk); addr = 32'h310; #1;
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL abort_miss dhit=%b exp=0", dhit); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h310) begin failures++; $display("FAIL abort_refill req=%b addr=%h exp 1/310", mem_req, mem_addr); end
        reset = 1;
        @(negedge clk); reset = 0; #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_req got=%b exp=0", mem_req); end
        checks++; if (dhit !== 1'b0) begin failures++; $display("FAIL abort_remiss dhit=%b exp=0", dhit); end
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h310) begin failures++; $display("FAIL abort_rerequest req=%b addr=%h exp 1/310", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 128'h000000D3_000000D2_000000D1_000000D0;
        @(negedge clk); mem_ack = 0; #1;
        checks++; if (dhit !== 1'b1 || rdata !== 32'hD0) begin failures++; $display("FAIL abort_final dhit=%b rdata=%h exp 1/000000d0", dhit, rdata); end
        @(negedge clk); rd_en = 0;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_byte_store();
        test_dirty_evict();
        test_store_miss();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
